// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the instruction prefetch stage
// and its environment.
package cpu_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } prefetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc_adder;
  } queue_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if: fetch-request, response, decode-side and redirect
// signals of the prefetch stage. master = prefetch stage, slave = environment.
interface inst_prefetch_queue_if;
  import cpu_pkg::*;

  logic              req_valid_o;
  logic              req_ready_i;
  logic [31:0]       req_addr_o;
  logic              resp_valid_i;
  logic [INST_W-1:0] resp_data_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [31:0]       pc_adder_o;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;

  modport master (
    output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_adder_o,
    input  req_ready_i, resp_valid_i, resp_data_i, inst_ready_i,
           redirect_i, redirect_pc_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_adder_o,
    output req_ready_i, resp_valid_i, resp_data_i, inst_ready_i,
           redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/inst_prefetch_queue_chk.sv
// inst_prefetch_queue_chk: simulation-only protocol and invariant checks for
// the prefetch stage.
module inst_prefetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int PTR_W = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic             resp_valid,
  input logic [CNT_W-1:0] outstanding,
  input logic [PTR_W:0]   occupancy,
  input logic             push,
  input logic             pop,
  input logic             full
);

  // A response with nothing in flight is a memory-side protocol error.
  resp_without_req_a: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (outstanding != '0))
    else $error("inst_prefetch_queue: response with no outstanding request");

  // Credits never exceed the queue size.
  credit_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(outstanding) + 32'(occupancy)) <= DEPTH)
    else $error("inst_prefetch_queue: outstanding plus occupancy exceeds DEPTH");

  // A push into a full queue must coincide with a pop.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    (push && full) |-> pop)
    else $error("inst_prefetch_queue: push into full queue without pop");

endmodule

// File: rtl/inst_prefetch_queue_fifo.sv
// inst_fifo: DEPTH-entry circular buffer of {inst, PC+4}. Pointers carry one
// extra wrap bit so full and empty are distinguishable; clr empties it.
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  queue_entry_t             wdata,
  output queue_entry_t             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  queue_entry_t   mem_r [DEPTH];
  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  logic           do_push_s;
  logic           do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  // A push into a full queue is legal only when the head leaves this cycle.
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      end
    end
  end

  // Entry storage, zeroed at reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s && !clr) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: in-order instruction prefetch with credit-limited
// requests, a DEPTH-entry {inst, PC+4} queue and branch-redirect flush.
// Optional feature macro: INST_PREFETCH_BYPASS_EN (same-cycle response
// bypass into an empty queue).
module inst_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                   clk_i,
  input logic                   rst_i,
  inst_prefetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  prefetch_state_t   state_r;
  prefetch_state_t   state_n_s;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  outstanding_n_s;
  logic [CNT_W-1:0]  discard_cnt_r;
  logic [CNT_W-1:0]  discard_n_s;
  logic [31:0]       fetch_pc_r;
  // PC of the next response still to be kept; responses return in request
  // order, so this single register is the tag of the response at the head.
  logic [31:0]       resp_pc_r;
  logic [PTR_W:0]    occupancy_s;
  logic [CNT_W:0]    credit_sum_s;
  logic              credit_ok_s;
  logic              req_valid_s;
  logic              accept_s;
  logic              resp_ok_s;
  logic              resp_keep_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  queue_entry_t      push_entry_s;
  queue_entry_t      head_entry_s;

  assign credit_sum_s = {1'b0, outstanding_r} + (CNT_W+1)'(occupancy_s);
  assign credit_ok_s  = (credit_sum_s < (CNT_W+1)'(DEPTH));
  // Held low while reset is asserted even though the counters read zero.
  assign req_valid_s  = rst_i & ~bus.redirect_i & credit_ok_s;
  assign accept_s     = req_valid_s & bus.req_ready_i;
  // Responses with nothing in flight are ignored.
  assign resp_ok_s    = bus.resp_valid_i & (outstanding_r != '0);

  assign bus.req_valid_o = req_valid_s;
  assign bus.req_addr_o  = fetch_pc_r;

  assign push_entry_s.inst     = bus.resp_data_i;
  assign push_entry_s.pc_adder = resp_pc_r + 32'd4;
  // A pop in the redirect cycle is void: the queue is being cleared.
  assign pop_s = ~fifo_empty_s & bus.inst_ready_i & ~bus.redirect_i;

`ifdef INST_PREFETCH_BYPASS_EN
  logic bypass_s;
  assign bypass_s         = fifo_empty_s & resp_keep_s;
  assign push_s           = resp_keep_s & ~(bypass_s & bus.inst_ready_i);
  assign bus.inst_valid_o = ~fifo_empty_s | bypass_s;
  assign bus.inst_o       = bypass_s ? push_entry_s.inst     : head_entry_s.inst;
  assign bus.pc_adder_o   = bypass_s ? push_entry_s.pc_adder : head_entry_s.pc_adder;
`else
  assign push_s           = resp_keep_s;
  assign bus.inst_valid_o = ~fifo_empty_s;
  assign bus.inst_o       = head_entry_s.inst;
  assign bus.pc_adder_o   = head_entry_s.pc_adder;
`endif

  // Outstanding count: accept adds one, a valid response removes one.
  always_comb begin
    outstanding_n_s = outstanding_r;
    case ({accept_s, resp_ok_s})
      2'b10:   outstanding_n_s = outstanding_r + CNT_W'(1);
      2'b01:   outstanding_n_s = outstanding_r - CNT_W'(1);
      default: outstanding_n_s = outstanding_r;
    endcase
  end

  // Fetch PC, response-tag PC and outstanding counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      outstanding_r <= '0;
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
    end else begin
      outstanding_r <= outstanding_n_s;
      if (bus.redirect_i) begin
        fetch_pc_r <= bus.redirect_pc_i;
        resp_pc_r  <= bus.redirect_pc_i;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (resp_keep_s) begin
          resp_pc_r <= resp_pc_r + 32'd4;
        end
      end
    end
  end

  // FSM state and discard counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r       <= RUN;
      discard_cnt_r <= '0;
    end else begin
      state_r       <= state_n_s;
      discard_cnt_r <= discard_n_s;
    end
  end

  // Next state: a redirect schedules every still-in-flight response for
  // discard (the one returning this cycle is already being dropped).
  always_comb begin
    state_n_s   = state_r;
    discard_n_s = discard_cnt_r;
    if (bus.redirect_i) begin
      discard_n_s = outstanding_r - CNT_W'(resp_ok_s);
      state_n_s   = (discard_n_s != '0) ? DRAIN : RUN;
    end else begin
      case (state_r)
        RUN: begin
          state_n_s = RUN;
        end
        DRAIN: begin
          if (resp_ok_s) begin
            discard_n_s = discard_cnt_r - CNT_W'(1);
            state_n_s   = (discard_n_s == '0) ? RUN : DRAIN;
          end else begin
            state_n_s = DRAIN;
          end
        end
        default: begin
          state_n_s   = RUN;
          discard_n_s = '0;
        end
      endcase
    end
  end

  // FSM output: responses are kept only in RUN and never in a redirect cycle.
  always_comb begin
    resp_keep_s = 1'b0;
    case (state_r)
      RUN:     resp_keep_s = resp_ok_s & ~bus.redirect_i;
      DRAIN:   resp_keep_s = 1'b0;
      default: resp_keep_s = 1'b0;
    endcase
  end

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (bus.redirect_i),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_entry_s),
    .rdata (head_entry_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (occupancy_s)
  );

  inst_prefetch_queue_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_chk (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .resp_valid  (bus.resp_valid_i),
    .outstanding (outstanding_r),
    .occupancy   (occupancy_s),
    .push        (push_s & ~bus.redirect_i),
    .pop         (pop_s),
    .full        (fifo_full_s)
  );

endmodule
